accel_conditioner: RTL and testbench

Per-axis conditioning stage between the SPI accelerometer controller and the display/servo consumers. Captures each new signed 16-bit X/Y/Z sample on the controller's update strobe and applies a sliding-window moving average. Converts each averaged value to sign + saturated magnitude and emits it with a one-cycle valid pulse. Replaces the free-running 2 Hz sampling register, so downstream blocks see exactly one filtered result per accelerometer update.

---
 rtl/accel_pkg.sv | 26 ++
 rtl/accel_conditioner_avg_window.sv | 48 ++++
 rtl/accel_conditioner.sv | 145 ++++++++++++++
 tb/tb_accel_conditioner.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// Shared types and helpers for the accelerometer conditioning stage.
package accel_pkg;

    localparam int SAMPLE_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_ACCUM   = 2'd2,
        ST_CONVERT = 2'd3
    } accel_state_e;

    // Absolute value clamped to max_mag; the 17-bit intermediate keeps |-32768| exact.
    function automatic logic [SAMPLE_W-1:0] sat_mag(input logic signed [SAMPLE_W-1:0] v,
                                                    input logic [SAMPLE_W-1:0] max_mag);
        logic [SAMPLE_W:0] ext;
        logic [SAMPLE_W:0] abs_v;
        ext   = {v[SAMPLE_W-1], v};
        abs_v = v[SAMPLE_W-1] ? ((SAMPLE_W+1)'(0) - ext) : ext;
        if (abs_v > {1'b0, max_mag}) begin
            return max_mag;
        end
        return abs_v[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/accel_conditioner_avg_window.sv
// One axis: circular sample window, running sum and floored average.
module avg_window
    import accel_pkg::*;
#(
    parameter int AVG_LOG2 = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       cap_en,
    input  logic                       avg_en,
    input  logic [AVG_LOG2-1:0]        wr_ptr,
    input  logic signed [SAMPLE_W-1:0] sample,
    output logic signed [SAMPLE_W-1:0] avg
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SUM_W = SAMPLE_W + AVG_LOG2;

    logic signed [SAMPLE_W-1:0] win_q [DEPTH];
    logic signed [SUM_W-1:0]    sum_q;
    logic signed [SUM_W-1:0]    sum_d;

    always_comb begin
        sum_d = sum_q
              - {{AVG_LOG2{win_q[wr_ptr][SAMPLE_W-1]}}, win_q[wr_ptr]}
              + {{AVG_LOG2{sample[SAMPLE_W-1]}}, sample};
    end

    // Dropping the low AVG_LOG2 bits of the sum is the arithmetic shift (floor toward -inf).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                win_q[i] <= '0;
            end
            sum_q <= '0;
            avg   <= '0;
        end else begin
            if (cap_en) begin
                win_q[wr_ptr] <= sample;
                sum_q         <= sum_d;
            end
            if (avg_en) begin
                avg <= sum_q[SUM_W-1:AVG_LOG2];
            end
        end
    end

endmodule

// File: rtl/accel_conditioner.sv
// Accelerometer conditioner: edge-captured X/Y/Z samples, moving average, sign + saturated magnitude.
// Optional deadband on the magnitude is enabled by defining ACCEL_DEADBAND_EN.
module accel_conditioner
    import accel_pkg::*;
#(
    parameter int AVG_LOG2 = 2,
    parameter int MAG_MAX  = 511,
    parameter int DEADBAND = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                data_update,
    input  logic [SAMPLE_W-1:0] data_x,
    input  logic [SAMPLE_W-1:0] data_y,
    input  logic [SAMPLE_W-1:0] data_z,
    input  logic                freeze,
    output logic [SAMPLE_W-1:0] mag_x,
    output logic [SAMPLE_W-1:0] mag_y,
    output logic [SAMPLE_W-1:0] mag_z,
    output logic                sign_x,
    output logic                sign_y,
    output logic                sign_z,
    output logic                out_valid,
    output logic                primed,
    output logic                overrun,
    output accel_state_e        dbg_state
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam logic [SAMPLE_W-1:0] MAG_CEIL  = SAMPLE_W'(MAG_MAX);
    localparam logic [SAMPLE_W-1:0] DB_LEVEL  = SAMPLE_W'(DEADBAND);
    localparam logic [AVG_LOG2:0]   FILL_FULL = (AVG_LOG2 + 1)'(DEPTH);
`ifdef ACCEL_DEADBAND_EN
    localparam bit DB_EN = 1'b1;
`else
    localparam bit DB_EN = 1'b0;
`endif

    accel_state_e               state_q;
    logic                       du_q;
    logic                       upd_edge;
    logic [AVG_LOG2-1:0]        wr_ptr_q;
    logic [AVG_LOG2:0]          fill_q;
    logic signed [SAMPLE_W-1:0] smp_x_q, smp_y_q, smp_z_q;
    logic signed [SAMPLE_W-1:0] avg_x, avg_y, avg_z;
    logic [SAMPLE_W:0]          conv_x, conv_y, conv_z;

    assign upd_edge  = data_update & ~du_q;
    assign dbg_state = state_q;

    // Returns {sign, magnitude}; a deadbanded value reads as +0.
    function automatic logic [SAMPLE_W:0] convert(input logic signed [SAMPLE_W-1:0] a);
        logic [SAMPLE_W-1:0] m;
        logic                s;
        m = sat_mag(a, MAG_CEIL);
        s = a[SAMPLE_W-1];
        if (DB_EN && (m < DB_LEVEL)) begin
            m = '0;
            s = 1'b0;
        end
        return {s, m};
    endfunction

    always_comb begin
        conv_x = convert(avg_x);
        conv_y = convert(avg_y);
        conv_z = convert(avg_z);
    end

    avg_window #(.AVG_LOG2(AVG_LOG2)) u_win_x (
        .clk(clk), .reset_n(reset_n),
        .cap_en(state_q == ST_CAPTURE), .avg_en(state_q == ST_ACCUM),
        .wr_ptr(wr_ptr_q), .sample(smp_x_q), .avg(avg_x)
    );
    avg_window #(.AVG_LOG2(AVG_LOG2)) u_win_y (
        .clk(clk), .reset_n(reset_n),
        .cap_en(state_q == ST_CAPTURE), .avg_en(state_q == ST_ACCUM),
        .wr_ptr(wr_ptr_q), .sample(smp_y_q), .avg(avg_y)
    );
    avg_window #(.AVG_LOG2(AVG_LOG2)) u_win_z (
        .clk(clk), .reset_n(reset_n),
        .cap_en(state_q == ST_CAPTURE), .avg_en(state_q == ST_ACCUM),
        .wr_ptr(wr_ptr_q), .sample(smp_z_q), .avg(avg_z)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            du_q      <= 1'b0;
            wr_ptr_q  <= '0;
            fill_q    <= '0;
            smp_x_q   <= '0;
            smp_y_q   <= '0;
            smp_z_q   <= '0;
            mag_x     <= '0;
            mag_y     <= '0;
            mag_z     <= '0;
            sign_x    <= 1'b0;
            sign_y    <= 1'b0;
            sign_z    <= 1'b0;
            out_valid <= 1'b0;
            primed    <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            du_q      <= data_update;
            out_valid <= 1'b0;
            // A frozen edge is discarded without flagging, even while busy.
            if (upd_edge && !freeze && (state_q != ST_IDLE)) begin
                overrun <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (upd_edge && !freeze) begin
                        smp_x_q <= data_x;
                        smp_y_q <= data_y;
                        smp_z_q <= data_z;
                        state_q <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    wr_ptr_q <= wr_ptr_q + AVG_LOG2'(1);
                    if (fill_q != FILL_FULL) begin
                        fill_q <= fill_q + (AVG_LOG2 + 1)'(1);
                    end
                    state_q <= ST_ACCUM;
                end
                ST_ACCUM: begin
                    state_q <= ST_CONVERT;
                end
                ST_CONVERT: begin
                    if (fill_q == FILL_FULL) begin
                        {sign_x, mag_x} <= conv_x;
                        {sign_y, mag_y} <= conv_y;
                        {sign_z, mag_z} <= conv_z;
                        out_valid       <= 1'b1;
                        primed          <= 1'b1;
                    end
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_accel_conditioner.sv
// Directed bench for accel_conditioner with hand-computed expectations (AVG_LOG2=2, MAG_MAX=511).
module tb_accel_conditioner;
    import accel_pkg::*;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         data_update;
    logic [15:0]  data_x, data_y, data_z;
    logic         freeze;
    logic [15:0]  mag_x, mag_y, mag_z;
    logic         sign_x, sign_y, sign_z;
    logic         out_valid, primed, overrun;
    accel_state_e dbg_state;

    int checks = 0;
    int errors = 0;

    accel_conditioner dut (
        .clk(clk), .reset_n(reset_n), .data_update(data_update),
        .data_x(data_x), .data_y(data_y), .data_z(data_z), .freeze(freeze),
        .mag_x(mag_x), .mag_y(mag_y), .mag_z(mag_z),
        .sign_x(sign_x), .sign_y(sign_y), .sign_z(sign_z),
        .out_valid(out_valid), .primed(primed), .overrun(overrun),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // One update edge; watches six cycles for out_valid (pulse count and first-seen latency).
    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                        output int pulses, output int lat);
        @(negedge clk);
        data_x = x; data_y = y; data_z = z; data_update = 1'b1;
        pulses = 0; lat = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 1) data_update = 1'b0;
            if (out_valid) begin
                pulses++;
                if (lat == 0) lat = i;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; freeze = 1'b0; data_update = 1'b0;
        data_x = 16'h1234; data_y = 16'h8001; data_z = 16'hFFFF;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (mag_x !== 16'd0 || mag_y !== 16'd0 || mag_z !== 16'd0) begin errors++; $display("FAIL reset_mags: got %0d %0d %0d want 0 0 0", mag_x, mag_y, mag_z); end
        checks++; if ({sign_x, sign_y, sign_z} !== 3'b000) begin errors++; $display("FAIL reset_signs: got %b want 000", {sign_x, sign_y, sign_z}); end
        checks++; if (primed !== 1'b0) begin errors++; $display("FAIL reset_primed: got %b want 0", primed); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    endtask

    task automatic test_prime();
        int p, l;
        for (int n = 1; n <= 3; n++) begin
            send(16'd100, 16'd0, 16'd0, p, l);
            checks++; if (p !== 0) begin errors++; $display("FAIL prime_early_valid: sample %0d got %0d pulses want 0", n, p); end
            checks++; if (primed !== 1'b0) begin errors++; $display("FAIL prime_early_primed: sample %0d got %b want 0", n, primed); end
        end
        send(16'd100, 16'd0, 16'd0, p, l);
        checks++; if (p !== 1) begin errors++; $display("FAIL prime_valid: got %0d pulses want 1", p); end
        checks++; if (l !== 4) begin errors++; $display("FAIL prime_latency: got %0d want 4", l); end
        checks++; if (mag_x !== 16'd100 || sign_x !== 1'b0) begin errors++; $display("FAIL prime_x: got mag %0d sign %b want 100 0", mag_x, sign_x); end
        checks++; if (primed !== 1'b1) begin errors++; $display("FAIL prime_primed: got %b want 1", primed); end
    endtask

    task automatic test_negative();
        int p, l;
        for (int n = 0; n < 4; n++) send(16'd100, 16'hFFD8, 16'd0, p, l);
        checks++; if (p !== 1) begin errors++; $display("FAIL neg_valid: got %0d pulses want 1", p); end
        checks++; if (mag_y !== 16'd40 || sign_y !== 1'b1) begin errors++; $display("FAIL neg_y40: got mag %0d sign %b want 40 1", mag_y, sign_y); end
        send(16'd100, 16'hFFFF, 16'd0, p, l);
        checks++; if (mag_y !== 16'd31 || sign_y !== 1'b1) begin errors++; $display("FAIL neg_mixed: got mag %0d sign %b want 31 1", mag_y, sign_y); end
        send(16'd100, 16'hFFFF, 16'd0, p, l);
        send(16'd100, 16'hFFFF, 16'd0, p, l);
        send(16'd100, 16'h0000, 16'd0, p, l);
        checks++; if (mag_y !== 16'd1 || sign_y !== 1'b1) begin errors++; $display("FAIL neg_floor: got mag %0d sign %b want 1 1", mag_y, sign_y); end
    endtask

    task automatic test_saturation();
        int p, l;
        for (int n = 0; n < 4; n++) send(16'd100, 16'd0, 16'h8000, p, l);
        checks++; if (mag_z !== 16'd511 || sign_z !== 1'b1) begin errors++; $display("FAIL sat_min: got mag %0d sign %b want 511 1", mag_z, sign_z); end
        for (int n = 0; n < 4; n++) send(16'd100, 16'd0, 16'h7FFF, p, l);
        checks++; if (mag_z !== 16'd511 || sign_z !== 1'b0) begin errors++; $display("FAIL sat_max: got mag %0d sign %b want 511 0", mag_z, sign_z); end
    endtask

    task automatic test_deadband();
        int p, l;
        logic [15:0] exp5;
`ifdef ACCEL_DEADBAND_EN
        exp5 = 16'd0;
`else
        exp5 = 16'd5;
`endif
        for (int n = 0; n < 4; n++) send(16'd5, 16'd0, 16'd0, p, l);
        checks++; if (mag_x !== exp5 || sign_x !== 1'b0) begin errors++; $display("FAIL deadband_5: got mag %0d sign %b want %0d 0", mag_x, sign_x, exp5); end
        for (int n = 0; n < 4; n++) send(16'd8, 16'd0, 16'd0, p, l);
        checks++; if (mag_x !== 16'd8) begin errors++; $display("FAIL deadband_edge: got %0d want 8", mag_x); end
    endtask

    task automatic test_overrun_freeze();
        int p, l, pulses;
        for (int n = 0; n < 4; n++) send(16'd200, 16'd0, 16'd0, p, l);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_pre: got %b want 0", overrun); end
        @(negedge clk);
        data_x = 16'd600; data_update = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) data_update = 1'b0;
            if (i == 2) begin data_x = 16'd1000; data_update = 1'b1; end
            if (i == 3) data_update = 1'b0;
            if (out_valid) pulses++;
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL overrun_pulses: got %0d want 1", pulses); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag: got %b want 1", overrun); end
        checks++; if (mag_x !== 16'd300) begin errors++; $display("FAIL overrun_avg: got %0d want 300", mag_x); end

        freeze = 1'b1;
        send(16'd4000, 16'd0, 16'd0, p, l);
        checks++; if (p !== 0) begin errors++; $display("FAIL freeze_valid: got %0d pulses want 0", p); end
        checks++; if (overrun !== 1'b1 || mag_x !== 16'd300) begin errors++; $display("FAIL freeze_hold: got ovr %b mag %0d want 1 300", overrun, mag_x); end
        freeze = 1'b0;

        // Freeze raised right after the edge: in-flight sample still completes.
        @(negedge clk);
        data_x = 16'd1000; data_update = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 1) begin data_update = 1'b0; freeze = 1'b1; end
            if (out_valid) pulses++;
        end
        checks++; if (pulses !== 1 || mag_x !== 16'd500) begin errors++; $display("FAIL freeze_inflight: got %0d pulses mag %0d want 1 500", pulses, mag_x); end
        send(16'd0, 16'd0, 16'd0, p, l);
        checks++; if (p !== 0 || mag_x !== 16'd500) begin errors++; $display("FAIL freeze_after: got %0d pulses mag %0d want 0 500", p, mag_x); end
        freeze = 1'b0;
    endtask

    task automatic test_back_to_back();
        int pulses;
        @(negedge clk);
        data_x = 16'd0; data_update = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) data_update = 1'b0;
            if (i == 4) data_update = 1'b1;
            if (i == 5) data_update = 1'b0;
            if (out_valid) pulses++;
        end
        checks++; if (pulses !== 2) begin errors++; $display("FAIL b2b_pulses: got %0d want 2", pulses); end
        checks++; if (mag_x !== 16'd400) begin errors++; $display("FAIL b2b_avg: got %0d want 400", mag_x); end
    endtask

    initial begin
        test_reset();
        test_prime();
        test_negative();
        test_saturation();
        test_deadband();
        test_overrun_freeze();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
